// File: rtl/pie_rx.sv
// rtl/pie_rx.sv - tag-side PIE decoder; CRC residue checks enabled by PIE_RX_CRC_EN
module pie_rx #(
  parameter logic [15:0] DELIM_MIN = 16'd40,
  parameter logic [15:0] CAL_MAX   = 16'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [15:0] tari,
  output logic [15:0] rtcal,
  output logic [15:0] trcal,
  output logic        trcal_valid,
  output logic        frame_active,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] bit_cnt,
  output logic        crc5_ok,
  output logic        crc16_ok
);

  typedef enum logic [2:0] {S_IDLE, S_DELIM, S_SYNC0, S_SYNC1, S_SYM} state_t;

  state_t      state;
  logic        rx_d;
  logic        hi_run;   // rx has stayed high since the last rise
  logic        first;    // next SYM rise may be TRcal
  logic [15:0] cnt;
  logic [15:0] pivot;
  logic [2:0]  bit_mod;
  logic [6:0]  shreg;

  logic        rise;
  logic        fall;
  logic        timeout;
  logic        sym_bit;
  logic [15:0] cnt_inc;

  assign rise    = ~rx_d & rx;
  assign fall    = rx_d & ~rx;
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign timeout = hi_run & rx & ({1'b0, cnt} == {rtcal, 1'b0});
  assign sym_bit = (cnt > pivot);

`ifdef PIE_RX_CRC_EN
  logic [15:0] crc16;
  logic [4:0]  crc5;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? 5'b01001 : 5'b00000);
  endfunction
`else
  assign crc5_ok  = 1'b0;
  assign crc16_ok = 1'b0;
`endif

  // Edge history, interval counter and the frame decode state machine
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      rx_d         <= 1'b1;
      hi_run       <= 1'b0;
      first        <= 1'b0;
      cnt          <= 16'd0;
      pivot        <= 16'd0;
      bit_mod      <= 3'd0;
      shreg        <= 7'd0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      byte_out     <= 8'd0;
      byte_valid   <= 1'b0;
      tari         <= 16'd0;
      rtcal        <= 16'd0;
      trcal        <= 16'd0;
      trcal_valid  <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      bit_cnt      <= 16'd0;
`ifdef PIE_RX_CRC_EN
      crc16        <= 16'hFFFF;
      crc5         <= 5'b01001;
      crc16_ok     <= 1'b0;
      crc5_ok      <= 1'b0;
`endif
    end else begin
      rx_d       <= rx;
      hi_run     <= rx & (rise | hi_run);
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      // IDLE times the delimiter from its falling edge, every other state times rise to rise
      if ((state == S_IDLE) ? fall : rise) begin
        cnt <= 16'd1;
      end else begin
        cnt <= cnt_inc;
      end

      case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_DELIM;
          end
        end

        S_DELIM: begin
          if (rise) begin
            if (cnt >= DELIM_MIN) begin
              state        <= S_SYNC0;
              frame_active <= 1'b1;
              bit_cnt      <= 16'd0;
              bit_mod      <= 3'd0;
              trcal_valid  <= 1'b0;
`ifdef PIE_RX_CRC_EN
              crc16        <= 16'hFFFF;
              crc5         <= 5'b01001;
              crc16_ok     <= 1'b0;
              crc5_ok      <= 1'b0;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_SYNC0: begin
          if (cnt > CAL_MAX) begin
            state        <= S_IDLE;
            frame_err    <= 1'b1;
            frame_active <= 1'b0;
            trcal_valid  <= 1'b0;
          end else if (rise) begin
            tari  <= cnt;
            state <= S_SYNC1;
          end
        end

        S_SYNC1: begin
          if (cnt > CAL_MAX) begin
            state        <= S_IDLE;
            frame_err    <= 1'b1;
            frame_active <= 1'b0;
            trcal_valid  <= 1'b0;
          end else if (rise) begin
            rtcal <= cnt;
            pivot <= {1'b0, cnt[15:1]};
            first <= 1'b1;
            state <= S_SYM;
          end
        end

        S_SYM: begin
          if (rise) begin
            first <= 1'b0;
            if (first && (cnt > rtcal)) begin
              trcal       <= cnt;
              trcal_valid <= 1'b1;
            end else if (cnt >= rtcal) begin
              state        <= S_IDLE;
              frame_err    <= 1'b1;
              frame_active <= 1'b0;
              trcal_valid  <= 1'b0;
            end else begin
              bit_out   <= sym_bit;
              bit_valid <= 1'b1;
              bit_mod   <= bit_mod + 3'd1;
              shreg     <= {shreg[5:0], sym_bit};
              if (bit_cnt != 16'hFFFF) begin
                bit_cnt <= bit_cnt + 16'd1;
              end
              if (bit_mod == 3'd7) begin
                byte_out   <= {shreg, sym_bit};
                byte_valid <= 1'b1;
              end
`ifdef PIE_RX_CRC_EN
              crc16 <= crc16_step(crc16, sym_bit);
              crc5  <= crc5_step(crc5, sym_bit);
`endif
            end
          end else if (timeout) begin
            state        <= S_IDLE;
            frame_done   <= 1'b1;
            frame_active <= 1'b0;
`ifdef PIE_RX_CRC_EN
            crc16_ok     <= (crc16 == 16'h1D0F);
            crc5_ok      <= (crc5 == 5'b00000);
`endif
          end else if (!rx && (cnt > CAL_MAX)) begin
            state        <= S_IDLE;
            frame_err    <= 1'b1;
            frame_active <= 1'b0;
            trcal_valid  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pie_rx.sv
// tb/tb_pie_rx.sv - directed-vector bench for pie_rx
`timescale 1ns/1ps
module tb_pie_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        bit_out;
  logic        bit_valid;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [15:0] tari;
  logic [15:0] rtcal;
  logic [15:0] trcal;
  logic        trcal_valid;
  logic        frame_active;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] bit_cnt;
  logic        crc5_ok;
  logic        crc16_ok;

  pie_rx dut (
    .clk(clk), .reset(reset), .rx(rx),
    .bit_out(bit_out), .bit_valid(bit_valid),
    .byte_out(byte_out), .byte_valid(byte_valid),
    .tari(tari), .rtcal(rtcal), .trcal(trcal), .trcal_valid(trcal_valid),
    .frame_active(frame_active), .frame_done(frame_done), .frame_err(frame_err),
    .bit_cnt(bit_cnt), .crc5_ok(crc5_ok), .crc16_ok(crc16_ok)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          n_bits = 0;
  int          n_bytes = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          fa_cycles = 0;
  int          last_bit_cyc = 0;
  int          done_cyc = 0;
  logic [63:0] rx_bits = '0;
  logic [7:0]  last_byte = '0;

  int b0, y0, d0, e0, f0;

  // Strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (bit_valid) begin
      rx_bits = {rx_bits[62:0], bit_out};
      n_bits++;
      last_bit_cyc = cyc;
    end
    if (byte_valid) begin
      last_byte = byte_out;
      n_bytes++;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (frame_err) n_err++;
    if (frame_active) fa_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b0 = n_bits; y0 = n_bytes; d0 = n_done; e0 = n_err; f0 = fa_cycles;
  endtask

  task automatic hold(input logic level, input int n);
    rx = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sym(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_sym(60, 20);
    else   send_sym(20, 20);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic preamble(input int delim, input logic with_trcal);
    hold(1'b0, delim);
    send_sym(20, 20);
    send_sym(80, 20);
    if (with_trcal) send_sym(200, 20);
  endtask

  function automatic logic [15:0] crc16_model(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [4:0] crc5_model(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? 5'b01001 : 5'b00000);
  endfunction

  logic [15:0] payload;
  logic [15:0] crc;
  logic [4:0]  c5;
  logic [31:0] word;
  logic        exp16;
  logic        exp5;

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    hold(1'b1, 5);

    // reset state
    check("rst_tari", tari, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_active", frame_active, 0);
    check("rst_byte", byte_out, 0);
    check("rst_trcal_valid", trcal_valid, 0);

    // query-style frame with TRcal
    snap();
    preamble(80, 1'b1);
    check("q_active_mid", frame_active, 1);
    send_bits(64'b1000, 4);
    hold(1'b1, 260);
    check("q_tari", tari, 40);
    check("q_rtcal", rtcal, 100);
    check("q_trcal", trcal, 220);
    check("q_trcal_valid", trcal_valid, 1);
    check("q_nbits", n_bits - b0, 4);
    check("q_bits", rx_bits[3:0], 4'b1000);
    check("q_bit_cnt", bit_cnt, 4);
    check("q_done", n_done - d0, 1);
    check("q_err", n_err - e0, 0);
    check("q_done_gap", done_cyc - last_bit_cyc, 200);
    check("q_active_end", frame_active, 0);
    check("q_bytes", n_bytes - y0, 0);

    // frame-sync only, minimum accepted delimiter, one full byte
    snap();
    preamble(40, 1'b0);
    send_bits(64'hA5, 8);
    hold(1'b1, 260);
    check("fs_trcal_valid", trcal_valid, 0);
    check("fs_trcal_kept", trcal, 220);
    check("fs_bytes", n_bytes - y0, 1);
    check("fs_byte", last_byte, 8'hA5);
    check("fs_bits", rx_bits[7:0], 8'hA5);
    check("fs_bit_cnt", bit_cnt, 8);
    check("fs_done", n_done - d0, 1);

    // glitch just under the delimiter minimum
    snap();
    hold(1'b0, 39);
    hold(1'b1, 100);
    check("gl_active", fa_cycles - f0, 0);
    check("gl_bits", n_bits - b0, 0);
    check("gl_done", n_done - d0, 0);
    check("gl_err", n_err - e0, 0);
    check("gl_bit_cnt", bit_cnt, 8);

    // oversize data symbol aborts the frame
    snap();
    preamble(80, 1'b1);
    send_bit(1'b0);
    send_sym(100, 20);
    hold(1'b1, 300);
    check("ov_err", n_err - e0, 1);
    check("ov_done", n_done - d0, 0);
    check("ov_active", frame_active, 0);
    check("ov_trcal_valid", trcal_valid, 0);
    check("ov_rtcal_kept", rtcal, 100);
    check("ov_trcal_kept", trcal, 220);
    check("ov_bit_cnt", bit_cnt, 1);

    snap();
    preamble(80, 1'b0);
    send_bits(64'b10, 2);
    hold(1'b1, 260);
    check("ov2_done", n_done - d0, 1);
    check("ov2_err", n_err - e0, 0);
    check("ov2_bits", rx_bits[1:0], 2'b10);
    check("ov2_bit_cnt", bit_cnt, 2);

    // reset in the middle of a frame
    snap();
    preamble(80, 1'b1);
    send_bits(64'b11, 2);
    hold(1'b1, 20);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mr_tari", tari, 0);
    check("mr_rtcal", rtcal, 0);
    check("mr_trcal", trcal, 0);
    check("mr_trcal_valid", trcal_valid, 0);
    check("mr_active", frame_active, 0);
    check("mr_bit_cnt", bit_cnt, 0);
    check("mr_byte", byte_out, 0);
    hold(1'b1, 300);
    check("mr_no_done", n_done - d0, 0);

    snap();
    preamble(80, 1'b1);
    send_bits(64'b011, 3);
    hold(1'b1, 260);
    check("mr2_tari", tari, 40);
    check("mr2_trcal", trcal, 220);
    check("mr2_bits", rx_bits[2:0], 3'b011);
    check("mr2_bit_cnt", bit_cnt, 3);
    check("mr2_done", n_done - d0, 1);

    // CRC16 frame, then the same frame with one payload bit flipped
    for (int pass = 0; pass < 2; pass++) begin
      payload = 16'hA5C3;
      crc = 16'hFFFF;
      for (int i = 15; i >= 0; i--) crc = crc16_model(crc, payload[i]);
      if (pass == 1) payload = payload ^ 16'h0100;
      word = {payload, ~crc};
      c5 = 5'b01001;
      for (int i = 31; i >= 0; i--) c5 = crc5_model(c5, word[i]);
`ifdef PIE_RX_CRC_EN
      exp16 = (pass == 0);
      exp5  = (c5 == 5'b00000);
`else
      exp16 = 1'b0;
      exp5  = 1'b0;
`endif
      snap();
      preamble(80, 1'b0);
      send_bits({32'd0, word}, 32);
      hold(1'b1, 260);
      check("crc_bits", rx_bits[31:0], word);
      check("crc_done", n_done - d0, 1);
      check("crc16_ok", crc16_ok, exp16);
      check("crc5_ok", crc5_ok, exp5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
